microwave_timer_ctrl: RTL and testbench



---
 rtl/microwave_pkg.sv | 17 +
 rtl/bcd_time_down.sv | 21 ++
 rtl/microwave_timer_ctrl.sv | 131 +++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state codes, BCD digit limits and timing default for the microwave timer.
package microwave_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic [3:0] SEC_MAX  = 4'd9;
  localparam logic [3:0] DSEC_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX  = 4'd9;
  localparam int TICKS_PER_SEC_DEF = 1000;
  function automatic logic is_zero(input logic [3:0] m, input logic [3:0] d, input logic [3:0] s);
    return (m == 4'd0) && (d == 4'd0) && (s == 4'd0);
  endfunction
endpackage

// File: rtl/bcd_time_down.sv
// bcd_time_down: combinational one-second decrement of an m:ds:s BCD time, with zero flag on the result.
module bcd_time_down
  import microwave_pkg::*;
(
  input  logic [3:0] i_min,
  input  logic [3:0] i_dsec,
  input  logic [3:0] i_sec,
  output logic [3:0] o_min,
  output logic [3:0] o_dsec,
  output logic [3:0] o_sec,
  output logic       o_zero
);
  logic w_sec_nz, w_dsec_nz;
  assign w_sec_nz  = i_sec != 4'd0;
  assign w_dsec_nz = i_dsec != 4'd0;
  assign o_sec  = w_sec_nz ? i_sec - 4'd1 : SEC_MAX;
  assign o_dsec = w_sec_nz ? i_dsec : (w_dsec_nz ? i_dsec - 4'd1 : DSEC_MAX);
  // 0:00 never reaches here in normal use; wrapping to 9:59 keeps the result legal BCD
  assign o_min  = (w_sec_nz || w_dsec_nz) ? i_min : (i_min == 4'd0 ? MIN_MAX : i_min - 4'd1);
  assign o_zero = is_zero(o_min, o_dsec, o_sec);
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad-loaded BCD countdown with door-gated heating and 0:00 alarm.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] dsec,
  output logic [3:0] sec,
  output logic       heating,
  output logic       alarm,
  output logic [2:0] state
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  state_t r_state, w_nxt;
  logic [3:0] r_min, r_dsec, r_sec, w_min, w_dsec, w_sec;
  logic [3:0] w_dn_min, w_dn_dsec, w_dn_sec;
  logic [PW-1:0] r_pre, w_pre;
  logic r_heat, r_alarm, w_dn_zero, w_zero, w_key, w_tick, w_go;
  assign w_zero = is_zero(r_min, r_dsec, r_sec);
  // a key that would push sec>5 into the dsec position is refused
  assign w_key  = key_valid && (key_code <= SEC_MAX) && (r_sec <= DSEC_MAX);
  assign w_tick = r_pre == PRE_LAST;
  assign w_go   = door_closed && start && !w_zero;
  bcd_time_down u_dn (
    .i_min (r_min),
    .i_dsec(r_dsec),
    .i_sec (r_sec),
    .o_min (w_dn_min),
    .o_dsec(w_dn_dsec),
    .o_sec (w_dn_sec),
    .o_zero(w_dn_zero)
  );
  always_comb begin
    w_nxt  = r_state;
    w_min  = r_min;
    w_dsec = r_dsec;
    w_sec  = r_sec;
    w_pre  = r_pre;
    case (r_state)
      S_IDLE, S_SETUP: begin
        if (stop_clear) begin
          w_nxt  = S_IDLE;
          w_min  = '0;
          w_dsec = '0;
          w_sec  = '0;
        end else if (door_closed && start) begin
          if (r_state == S_SETUP && w_go) begin
            w_nxt = S_RUN;
            w_pre = '0;
          end
        end else if (door_closed && w_key) begin
          w_nxt  = S_SETUP;
          w_min  = r_dsec;
          w_dsec = r_sec;
          w_sec  = key_code;
        end
      end
      S_RUN: begin
        if (stop_clear || !door_closed) begin
          w_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_pre  = '0;
          w_min  = w_dn_min;
          w_dsec = w_dn_dsec;
          w_sec  = w_dn_sec;
          w_nxt  = w_dn_zero ? S_DONE : S_RUN;
        end else begin
          w_pre = r_pre + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop_clear) begin
          w_nxt  = S_IDLE;
          w_min  = '0;
          w_dsec = '0;
          w_sec  = '0;
        end else if (w_go) begin
          w_nxt = S_RUN;
          w_pre = '0;
        end
      end
      S_DONE: begin
        w_min  = '0;
        w_dsec = '0;
        w_sec  = '0;
        w_nxt  = (stop_clear || !door_closed) ? S_IDLE : S_DONE;
      end
      default: begin
        w_nxt  = S_IDLE;
        w_min  = '0;
        w_dsec = '0;
        w_sec  = '0;
        w_pre  = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_min   <= '0;
      r_dsec  <= '0;
      r_sec   <= '0;
      r_pre   <= '0;
      r_heat  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_min   <= w_min;
      r_dsec  <= w_dsec;
      r_sec   <= w_sec;
      r_pre   <= w_pre;
      r_heat  <= w_nxt == S_RUN;
      r_alarm <= w_nxt == S_DONE;
    end
  end
  assign min     = r_min;
  assign dsec    = r_dsec;
  assign sec     = r_sec;
  assign heating = r_heat;
  assign alarm   = r_alarm;
  assign state   = r_state;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: directed plan plus random traffic against a seconds-based reference model.
module tb_microwave_timer_ctrl;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic key_valid = 1'b0, start = 1'b0, stop_clear = 1'b0, door_closed = 1'b1;
  logic [3:0] key_code = 4'd0;
  logic [3:0] min, dsec, sec;
  logic heating, alarm;
  logic [2:0] state;
  int n_vec = 0, n_err = 0;
  int m_st, m_min, m_dsec, m_sec, m_pre;
  microwave_timer_ctrl #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .min(min), .dsec(dsec), .sec(sec), .heating(heating), .alarm(alarm), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_min = 0; m_dsec = 0; m_sec = 0; m_pre = 0;
  endtask
  task automatic set_secs(input int t);
    m_min = t / 60; m_dsec = (t % 60) / 10; m_sec = t % 10;
  endtask
  task automatic model_step();
    int tot;
    tot = m_min * 60 + m_dsec * 10 + m_sec;
    if (m_st == 0 || m_st == 1) begin
      if (stop_clear) begin m_st = 0; set_secs(0); end
      else if (!door_closed) ;
      else if (start) begin if (m_st == 1 && tot != 0) begin m_st = 2; m_pre = 0; end end
      else if (key_valid && key_code <= 9 && m_sec <= 5) begin
        m_min = m_dsec; m_dsec = m_sec; m_sec = key_code; m_st = 1;
      end
    end else if (m_st == 2) begin
      if (stop_clear || !door_closed) m_st = 3;
      else if (m_pre == T - 1) begin
        m_pre = 0; set_secs(tot - 1);
        if (tot == 1) m_st = 4;
      end else m_pre++;
    end else if (m_st == 3) begin
      if (stop_clear) begin m_st = 0; set_secs(0); end
      else if (door_closed && start && tot != 0) begin m_st = 2; m_pre = 0; end
    end else if (stop_clear || !door_closed) m_st = 0;
  endtask
  task automatic check_all();
    chk("state", state, m_st);
    chk("time", {min, dsec, sec}, m_min * 256 + m_dsec * 16 + m_sec);
    chk("heating", heating, m_st == 2);
    chk("alarm", alarm, m_st == 4);
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
  endtask
  task automatic press(input int k);
    key_valid = 1'b1; key_code = 4'(k); step();
  endtask
  task automatic go();
    start = 1'b1; step();
  endtask
  task automatic clr();
    stop_clear = 1'b1; step();
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_state", state, 0);
    chk("rst_time", {min, dsec, sec}, 0);
    chk("rst_outs", {heating, alarm}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    press(1); press(3); press(0);
    chk("key130", {min, dsec, sec}, 12'h130);
    chk("key_setup", state, 1);
    press(7);
    chk("key7", {min, dsec, sec}, 12'h307);
    press(8);
    chk("key8_rej", {min, dsec, sec}, 12'h307);
    clr();
    press(1); go();
    chk("heat_on", heating, 1);
    idle(3);
    chk("run_3clk", state, 2);
    step();
    chk("done", state, 4);
    chk("done_alarm", {alarm, heating}, 2'b10);
    chk("done_time", {min, dsec, sec}, 0);
    clr();
    chk("done_clr", {state, alarm}, 0);
    press(1); press(0); press(0); go(); idle(4);
    chk("borrow2", {min, dsec, sec}, 12'h059);
    clr(); clr();
    press(1); press(0); go(); idle(4);
    chk("borrow1", {min, dsec, sec}, 12'h009);
    clr(); clr();
    press(5); go();
    door_closed = 1'b0; step();
    chk("door_pause", state, 3);
    chk("door_heat", heating, 0);
    idle(20);
    chk("pause_hold", {min, dsec, sec}, 12'h005);
    go();
    chk("start_open", state, 3);
    door_closed = 1'b1; step();
    go(); idle(3);
    chk("resume_3", {min, dsec, sec}, 12'h005);
    step();
    chk("resume_4", {min, dsec, sec}, 12'h004);
    clr();
    stop_clear = 1'b1; start = 1'b1; step();
    chk("sc_start", {state, min, dsec, sec}, 0);
    press(0); go();
    chk("start_zero", state, 1);
    clr();
    press(2); press(3); press(0); go(); idle(2);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_state", state, 0);
    chk("arst_all", {min, dsec, sec, heating, alarm}, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4000; i++) begin
      if (door_closed ? ($urandom % 50 == 0) : ($urandom % 8 == 0)) door_closed = ~door_closed;
      key_valid  = ($urandom % 3) == 0;
      key_code   = 4'($urandom % 16);
      start      = ($urandom % 8) == 0;
      stop_clear = ($urandom % 40) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
